inst_fetch_resp: RTL and testbench
==================================

// Module: inst_fetch_resp
// PURPOSE
// - Responder end of the instruction-fetch interface: accepts inst_ena/inst_addr from the fetch stage and returns a 32-bit instruction.
// - Holds a one-line (8-byte) fetch buffer. A hit returns in the same cycle; a miss stalls fetch and runs a 64-bit read on the memory bus.
// - Sits between the fetch stage and the memory arbiter.
// PARAMETERS
// - TIMEOUT_CYC  255  max WAIT cycles before a bus error (used only with IFETCH_TIMEOUT_EN)
// PORTS
// - clk         in   1   core clock, all state on posedge
// - rst_n       in   1   asynchronous active-low reset
// - inst_ena    in   1   fetch request valid
// - inst_addr   in   64  byte address of the instruction
// - flush       in   1   invalidate the fetch buffer (fence.i)
// - inst        out  32  instruction; 0 when inst_valid=0
// - inst_valid  out  1   inst is valid this cycle
// - stall       out  1   fetch stage must hold inst_addr
// - mem_req     out  1   memory read request, held until mem_gnt
// - mem_addr    out  64  line address, {addr[63:3],3'b000}
// - mem_gnt     in   1   request accepted this cycle
// - mem_rvalid  in   1   mem_rdata valid; arrives >=1 cycle after mem_gnt
// - mem_rdata   in   64  line data, little-endian
// - bus_err     out  1   1-cycle pulse on fetch timeout
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE, buf_valid=0, buf_tag=0, buf_data=0, req_addr=0, wait_cnt=0.
//   Outputs at reset: inst=0, inst_valid=0, stall=0, mem_req=0, mem_addr=0, bus_err=0.
// - Hit: state==IDLE && inst_ena && buf_valid && buf_tag==inst_addr[63:3] && !flush.
//   Combinational result: inst_valid=1, stall=0, inst=inst_addr[2] ? buf_data[63:32] : buf_data[31:0]. Latency 0.
// - Miss: IDLE && inst_ena && !hit.
//   stall=1, inst_valid=0. At the clock edge: req_addr<=inst_addr, state<=REQ.
// - FSM:
//   - IDLE->REQ on miss.
//   - REQ: mem_req=1, mem_addr={req_addr[63:3],3'b0}. REQ->WAIT on mem_gnt.
//   - WAIT: mem_req=0. On mem_rvalid: buf_data<=mem_rdata, buf_tag<=req_addr[63:3], buf_valid<=!flush_pend, state<=IDLE.
//   - stall=1 in REQ and WAIT.
//   - After a fill the buffer holds the line, so the fetch hits on the first IDLE cycle. Miss latency = 1 + grant wait + rvalid wait + 1 cycles.
// - inst_addr change during REQ/WAIT: the fill completes to req_addr. The new address is evaluated in IDLE and may miss again.
// - inst_ena=0: inst_valid=0, stall=0 in IDLE, and no miss starts. An in-flight fill continues and stall stays 1 until it ends.
// - flush:
//   - In IDLE: buf_valid<=0 at the edge, and the same-cycle lookup is forced to miss.
//   - In REQ/WAIT: set flush_pend. The fill lands with buf_valid=0. flush_pend clears on return to IDLE.
// - mem_rvalid in IDLE or REQ is ignored. mem_gnt outside REQ is ignored.
// - Reset mid-fill aborts immediately. A late mem_rvalid after reset is ignored (state is IDLE).
// CONFIGURATION
// - IFETCH_TIMEOUT_EN defined:
//   - 8-bit wait_cnt clears on entering WAIT and increments each WAIT cycle without mem_rvalid.
//   - When wait_cnt==TIMEOUT_CYC: bus_err=1 for one cycle, state<=IDLE, buffer unchanged.
//   - In that cycle: inst=32'h00000013 (NOP), inst_valid=1, stall=0.
// - IFETCH_TIMEOUT_EN undefined: WAIT lasts until mem_rvalid, with no limit. bus_err tied 0; wait_cnt not built.
// TESTING
// - Cold miss:
//   - Stimulus: reset, inst_ena=1, addr=0x0; gnt 1 cycle after req; rvalid with rdata=0x00500093_00000013 2 cycles later.
//   - Response: stall high 4 cycles, mem_addr=0x0; then inst=0x00000013 valid, stall=0.
// - Same-line hit: addr=0x4 after that fill -> inst=0x00500093 same cycle, mem_req stays 0.
// - Line crossing: addr 0x8 -> miss, mem_addr=0x8. Changing inst_addr to 0x10 during WAIT still fills tag 0x1. 0x10 then misses again.
// - Flush during WAIT: fill for 0x20 completes, buf_valid=0. Next fetch of 0x20 issues mem_req again.
// - Async reset in WAIT: rst_n=0 mid-cycle -> mem_req/stall/inst_valid=0 immediately. A later rvalid produces no inst_valid.
// - IFETCH_TIMEOUT_EN, TIMEOUT_CYC=8, rvalid never sent: bus_err pulses 8 cycles after entering WAIT, with inst=0x00000013 valid.
//   The next fetch misses again.

Source files
------------

// File: rtl/inst_fetch_resp.sv
// inst_fetch_resp: responder end of the instruction-fetch interface.
// Holds one 8-byte fetch line. Hits return combinationally. Misses stall fetch
// and run a single 64-bit read on the memory bus.
// Optional build macro: IFETCH_TIMEOUT_EN. It adds a WAIT-state watchdog that
// aborts a fill after TIMEOUT_CYC cycles, pulses bus_err and returns a NOP.
`timescale 1ns/1ps

module inst_fetch_resp #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inst_ena,
  input  logic [63:0] inst_addr,
  input  logic        flush,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        stall,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata,
  output logic        bus_err
);

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_buf_valid;
  logic [60:0] r_buf_tag;
  logic [63:0] r_buf_data;
  logic [60:0] r_req_line;   // line part of req_addr; the low bits never reach the bus
  logic        r_flush_pend;

  logic w_hit;
  logic w_miss;
  logic w_fill;
  logic w_timeout;
  logic w_unused;

  assign w_hit  = (r_state == S_IDLE) && inst_ena && r_buf_valid &&
                  (r_buf_tag == inst_addr[63:3]) && !flush;
  assign w_miss = (r_state == S_IDLE) && inst_ena && !w_hit;
  assign w_fill = (r_state == S_WAIT) && mem_rvalid;

`ifdef IFETCH_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYC);

  logic [7:0] r_wait_cnt;

  // A returning beat wins over the watchdog in the same cycle.
  assign w_timeout = (r_state == S_WAIT) && !mem_rvalid && (r_wait_cnt == TIMEOUT_LIM);
  assign w_unused  = &{1'b0, inst_addr[1:0]};

  // Count WAIT cycles spent without read data; restarts on every grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if ((r_state == S_REQ) && mem_gnt) begin
      r_wait_cnt <= '0;
    end else if ((r_state == S_WAIT) && !mem_rvalid) begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign w_unused  = &{1'b0, inst_addr[1:0], 8'(TIMEOUT_CYC)};
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values, independent of statement order.
      r_state <= w_state_nxt;
    end
  end

  // Next-state and output decode. While reset is asserted every output is
  // held at zero, so a fill is visibly aborted the moment rst_n drops.
  always_comb begin
    // NOTE: every output gets a default first, so no path through the case
    // leaves a signal unassigned and no latch is inferred.
    w_state_nxt = r_state;
    inst        = '0;
    inst_valid  = 1'b0;
    stall       = 1'b0;
    mem_req     = 1'b0;
    mem_addr    = '0;
    bus_err     = 1'b0;
    if (rst_n) begin
      unique case (r_state)
        S_IDLE: begin
          if (w_hit) begin
            inst_valid = 1'b1;
            inst       = inst_addr[2] ? r_buf_data[63:32] : r_buf_data[31:0];
          end else if (w_miss) begin
            stall       = 1'b1;
            w_state_nxt = S_REQ;
          end
        end
        S_REQ: begin
          stall    = 1'b1;
          mem_req  = 1'b1;
          mem_addr = {r_req_line, 3'b000};
          if (mem_gnt) w_state_nxt = S_WAIT;
        end
        S_WAIT: begin
          stall = 1'b1;
          if (w_fill) begin
            w_state_nxt = S_IDLE;
          end else if (w_timeout) begin
            stall       = 1'b0;
            bus_err     = 1'b1;
            inst        = NOP_INST;
            inst_valid  = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Fetch buffer, captured miss line and pending-flush flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the line buffer is a plain register, not a RAM, so it can be
      // cleared here; no array-style storage needs resetting.
      r_buf_valid  <= 1'b0;
      r_buf_tag    <= '0;
      r_buf_data   <= '0;
      r_req_line   <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      if (w_miss) r_req_line <= inst_addr[63:3];

      // A flush seen at any point during the fill, including the data cycle,
      // leaves the landed line invalid.
      if (w_fill) begin
        r_buf_data  <= mem_rdata;
        r_buf_tag   <= r_req_line;
        r_buf_valid <= !(r_flush_pend || flush);
      end else if ((r_state == S_IDLE) && flush) begin
        r_buf_valid <= 1'b0;
      end

      if (w_state_nxt == S_IDLE) begin
        r_flush_pend <= 1'b0;
      end else if (flush && (r_state != S_IDLE)) begin
        r_flush_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_resp.sv
// Self-checking bench for inst_fetch_resp: a per-cycle vector table covering
// cold miss, hits, line crossing and flushes, then hand-written sequences for
// async reset mid-fill and the WAIT watchdog (IFETCH_TIMEOUT_EN).
`timescale 1ns/1ps

module tb_inst_fetch_resp;

  logic        clk;
  logic        rst_n;
  logic        inst_ena;
  logic [63:0] inst_addr;
  logic        flush;
  logic [31:0] inst;
  logic        inst_valid;
  logic        stall;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic        bus_err;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        ena;
    logic [63:0] addr;
    logic        fl;
    logic        gnt;
    logic        rv;
    logic [63:0] rdata;
    logic [31:0] e_inst;
    logic        e_valid;
    logic        e_stall;
    logic        e_req;
    logic [63:0] e_maddr;
  } vec_t;

  vec_t vecs[$];

  inst_fetch_resp #(.TIMEOUT_CYC(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .inst_ena   (inst_ena),
    .inst_addr  (inst_addr),
    .flush      (flush),
    .inst       (inst),
    .inst_valid (inst_valid),
    .stall      (stall),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .bus_err    (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic ena, input logic [63:0] addr,
                              input logic fl, input logic gnt, input logic rv,
                              input logic [63:0] rdata, input logic [31:0] e_inst,
                              input logic e_valid, input logic e_stall,
                              input logic e_req, input logic [63:0] e_maddr);
    vec_t v;
    v.ena = ena;   v.addr = addr;   v.fl = fl;   v.gnt = gnt;   v.rv = rv;
    v.rdata = rdata;   v.e_inst = e_inst;   v.e_valid = e_valid;
    v.e_stall = e_stall;   v.e_req = e_req;   v.e_maddr = e_maddr;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ena, input logic [63:0] addr, input logic fl,
                       input logic gnt, input logic rv, input logic [63:0] rdata);
    inst_ena   = ena;
    inst_addr  = addr;
    flush      = fl;
    mem_gnt    = gnt;
    mem_rvalid = rv;
    mem_rdata  = rdata;
  endtask

  task automatic check_outs(input string tag, input logic [31:0] e_inst,
                            input logic e_valid, input logic e_stall, input logic e_req,
                            input logic [63:0] e_maddr, input logic e_berr);
    check({tag, ".inst"},       64'(inst),       64'(e_inst));
    check({tag, ".inst_valid"}, 64'(inst_valid), 64'(e_valid));
    check({tag, ".stall"},      64'(stall),      64'(e_stall));
    check({tag, ".mem_req"},    64'(mem_req),    64'(e_req));
    check({tag, ".mem_addr"},   mem_addr,        e_maddr);
    check({tag, ".bus_err"},    64'(bus_err),    64'(e_berr));
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle: drive inputs, sample on the falling edge, advance.
  task automatic cyc(input string tag, input logic ena, input logic [63:0] addr,
                     input logic fl, input logic gnt, input logic rv,
                     input logic [63:0] rdata, input logic [31:0] e_inst,
                     input logic e_valid, input logic e_stall, input logic e_req,
                     input logic [63:0] e_maddr, input logic e_berr);
    drive(ena, addr, fl, gnt, rv, rdata);
    @(negedge clk);
    check_outs(tag, e_inst, e_valid, e_stall, e_req, e_maddr, e_berr);
    tick();
  endtask

  initial begin
    //           ena addr   fl gnt rv  rdata                  inst          v  st rq maddr
    // Cold miss of line 0: grant in the first REQ cycle, data two cycles later.
    vecs.push_back(mk(1, 64'h00, 0, 0, 0, 64'h0,                   32'h0,        0, 1, 0, 64'h00));
    vecs.push_back(mk(1, 64'h00, 0, 1, 0, 64'h0,                   32'h0,        0, 1, 1, 64'h00));
    vecs.push_back(mk(1, 64'h00, 0, 0, 0, 64'h0,                   32'h0,        0, 1, 0, 64'h00));
    vecs.push_back(mk(1, 64'h00, 0, 0, 1, 64'h00500093_00000013,   32'h0,        0, 1, 0, 64'h00));
    vecs.push_back(mk(1, 64'h00, 0, 0, 0, 64'h0,                   32'h00000013, 1, 0, 0, 64'h00));
    // Same-line hit on the upper word; then idle with a stray grant.
    vecs.push_back(mk(1, 64'h04, 0, 0, 0, 64'h0,                   32'h00500093, 1, 0, 0, 64'h00));
    vecs.push_back(mk(0, 64'h04, 0, 1, 0, 64'h0,                   32'h0,        0, 0, 0, 64'h00));
    // Line crossing to 0x8; address moves to 0x10 during WAIT.
    vecs.push_back(mk(1, 64'h08, 0, 0, 0, 64'h0,                   32'h0,        0, 1, 0, 64'h00));
    vecs.push_back(mk(1, 64'h08, 0, 0, 0, 64'h0,                   32'h0,        0, 1, 1, 64'h08));
    vecs.push_back(mk(1, 64'h08, 0, 1, 0, 64'h0,                   32'h0,        0, 1, 1, 64'h08));
    vecs.push_back(mk(1, 64'h10, 0, 0, 0, 64'h0,                   32'h0,        0, 1, 0, 64'h00));
    vecs.push_back(mk(1, 64'h10, 0, 0, 1, 64'h11111111_22222222,   32'h0,        0, 1, 0, 64'h00));
    vecs.push_back(mk(1, 64'h0C, 0, 0, 0, 64'h0,                   32'h11111111, 1, 0, 0, 64'h00));
    vecs.push_back(mk(1, 64'h10, 0, 0, 0, 64'h0,                   32'h0,        0, 1, 0, 64'h00));
    vecs.push_back(mk(1, 64'h10, 0, 1, 0, 64'h0,                   32'h0,        0, 1, 1, 64'h10));
    vecs.push_back(mk(1, 64'h10, 0, 0, 1, 64'h33333333_44444444,   32'h0,        0, 1, 0, 64'h00));
    // Stray rvalid in IDLE must not overwrite the buffer.
    vecs.push_back(mk(1, 64'h14, 0, 0, 1, 64'hDEADDEAD_DEADDEAD,   32'h33333333, 1, 0, 0, 64'h00));
    vecs.push_back(mk(1, 64'h10, 0, 0, 0, 64'h0,                   32'h44444444, 1, 0, 0, 64'h00));
    // Flush during WAIT: line 0x20 lands invalid and is fetched again.
    vecs.push_back(mk(1, 64'h20, 0, 0, 0, 64'h0,                   32'h0,        0, 1, 0, 64'h00));
    vecs.push_back(mk(1, 64'h20, 0, 1, 0, 64'h0,                   32'h0,        0, 1, 1, 64'h20));
    vecs.push_back(mk(1, 64'h20, 1, 0, 0, 64'h0,                   32'h0,        0, 1, 0, 64'h00));
    vecs.push_back(mk(1, 64'h20, 0, 0, 1, 64'h55555555_66666666,   32'h0,        0, 1, 0, 64'h00));
    vecs.push_back(mk(1, 64'h20, 0, 0, 0, 64'h0,                   32'h0,        0, 1, 0, 64'h00));
    vecs.push_back(mk(1, 64'h20, 0, 1, 0, 64'h0,                   32'h0,        0, 1, 1, 64'h20));
    vecs.push_back(mk(1, 64'h20, 0, 0, 1, 64'h77777777_88888888,   32'h0,        0, 1, 0, 64'h00));
    vecs.push_back(mk(1, 64'h20, 0, 0, 0, 64'h0,                   32'h88888888, 1, 0, 0, 64'h00));
    // Flush in IDLE forces a miss on a resident line; rvalid in REQ ignored.
    vecs.push_back(mk(1, 64'h24, 1, 0, 0, 64'h0,                   32'h0,        0, 1, 0, 64'h00));
    vecs.push_back(mk(1, 64'h24, 0, 0, 1, 64'hEEEEEEEE_EEEEEEEE,   32'h0,        0, 1, 1, 64'h20));
    vecs.push_back(mk(1, 64'h24, 0, 1, 0, 64'h0,                   32'h0,        0, 1, 1, 64'h20));
    vecs.push_back(mk(1, 64'h24, 0, 0, 1, 64'h99999999_AAAAAAAA,   32'h0,        0, 1, 0, 64'h00));
    vecs.push_back(mk(1, 64'h24, 0, 0, 0, 64'h0,                   32'h99999999, 1, 0, 0, 64'h00));

    // Reset with a fetch already requested: every output must read zero.
    rst_n = 1'b0;
    drive(1, 64'h0, 0, 0, 0, 64'h0);
    #3;
    check_outs("reset", 32'h0, 0, 0, 0, 64'h0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      cyc($sformatf("v%0d", i), vecs[i].ena, vecs[i].addr, vecs[i].fl, vecs[i].gnt,
          vecs[i].rv, vecs[i].rdata, vecs[i].e_inst, vecs[i].e_valid,
          vecs[i].e_stall, vecs[i].e_req, vecs[i].e_maddr, 1'b0);
    end

    // Async reset in WAIT: outputs drop at once, a late rvalid is ignored.
    cyc("rst.miss", 1, 64'h40, 0, 0, 0, 64'h0, 32'h0, 0, 1, 0, 64'h00, 0);
    cyc("rst.req",  1, 64'h40, 0, 1, 0, 64'h0, 32'h0, 0, 1, 1, 64'h40, 0);
    drive(1, 64'h40, 0, 0, 0, 64'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("rst.async", 32'h0, 0, 0, 0, 64'h0, 0);
    tick();
    rst_n = 1'b1;
    cyc("rst.late_rv", 0, 64'h40, 0, 0, 1, 64'hBBBBBBBB_BBBBBBBB, 32'h0, 0, 0, 0, 64'h00, 0);
    cyc("rst.remiss",  1, 64'h40, 0, 0, 0, 64'h0, 32'h0, 0, 1, 0, 64'h00, 0);
    cyc("rst.req2",    1, 64'h40, 0, 1, 0, 64'h0, 32'h0, 0, 1, 1, 64'h40, 0);
    cyc("rst.fill",    1, 64'h40, 0, 0, 1, 64'hCCCCCCCC_DDDDDDDD, 32'h0, 0, 1, 0, 64'h00, 0);
    cyc("rst.hit",     1, 64'h44, 0, 0, 0, 64'h0, 32'hCCCCCCCC, 1, 0, 0, 64'h00, 0);

    // Long WAIT with no read data: watchdog fires after 8 cycles when built in.
    cyc("to.miss", 1, 64'h80, 0, 0, 0, 64'h0, 32'h0, 0, 1, 0, 64'h00, 0);
    cyc("to.req",  1, 64'h80, 0, 1, 0, 64'h0, 32'h0, 0, 1, 1, 64'h80, 0);
    for (int k = 0; k < 8; k++) begin
      cyc($sformatf("to.wait%0d", k), 1, 64'h80, 0, 0, 0, 64'h0, 32'h0, 0, 1, 0, 64'h00, 0);
    end
`ifdef IFETCH_TIMEOUT_EN
    cyc("to.fire",  1, 64'h80, 0, 0, 0, 64'h0, 32'h00000013, 1, 0, 0, 64'h00, 1);
    cyc("to.keep",  1, 64'h44, 0, 0, 0, 64'h0, 32'hCCCCCCCC, 1, 0, 0, 64'h00, 0);
    cyc("to.remiss",1, 64'h80, 0, 0, 0, 64'h0, 32'h0, 0, 1, 0, 64'h00, 0);
    cyc("to.req2",  1, 64'h80, 0, 1, 0, 64'h0, 32'h0, 0, 1, 1, 64'h80, 0);
`else
    cyc("to.nofire",1, 64'h80, 0, 0, 0, 64'h0, 32'h0, 0, 1, 0, 64'h00, 0);
    cyc("to.wait9", 1, 64'h80, 0, 0, 0, 64'h0, 32'h0, 0, 1, 0, 64'h00, 0);
`endif
    cyc("to.fill",  1, 64'h80, 0, 0, 1, 64'h0BADF00D_12345678, 32'h0, 0, 1, 0, 64'h00, 0);
    cyc("to.hit",   1, 64'h84, 0, 0, 0, 64'h0, 32'h0BADF00D, 1, 0, 0, 64'h00, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
